nonce_sequencer: RTL and testbench
==================================

Name: nonce_sequencer

Overview:
- Initiator side of the hash-state accumulator protocol. Drives the Block phase code and nonce_sig into the eight H accumulators (H0..H7) and tells the round core which chunk to load and which round to run.
- After each double hash it reads back the top digest word and compares it against the target. It then either steps the nonce, reusing the chunk-1 midstate, or reports the result.
- Sits between the miner top-level control (start/target) and the compression core plus accumulators.

Parameters:
ROUNDS, 64, compression rounds per chunk; legal range 2..64.
NONCE_START, 32'h00000000, first nonce tried after start.
NONCE_LAST, 32'hFFFFFFFF, last nonce tried before giving up.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin search; sampled only in IDLE
abort  input  1  stop search; return to IDLE on next edge
target_hi  input  32  unsigned threshold for the digest top word; sampled at start
digest_hi  input  32  H0 accumulator output (final digest top word)
Block  output  2  phase code to accumulators: 0 init, 1 chunk1 done, 2 chunk2 done, 3 second hash done
nonce_sig  output  1  0 = first nonce (full IV init); 1 = later nonce (midstate reuse)
load_chunk  output  1  1-cycle pulse: core loads chunk chunk_sel and IV/midstate
chunk_sel  output  2  0 header chunk1, 1 header chunk2 + nonce, 2 padded first digest
round  output  6  current round index 0..ROUNDS-1
round_valid  output  1  core executes round this cycle
nonce  output  32  nonce under test
busy  output  1  high in any state except IDLE
done  output  1  1-cycle pulse at end of search
found  output  1  result level; held until next accepted start
found_nonce  output  32  winning nonce; valid while found=1

Behaviour:
- Reset (async, rst_n=0) and IDLE outputs:
  - Block=0, nonce_sig=0, load_chunk=0, chunk_sel=0, round=0, round_valid=0.
  - nonce=NONCE_START, busy=0, done=0, found=0, found_nonce=0.
- Reset mid-search forces these values immediately.
- States: IDLE, INIT, RND, ADD, CHECK. Internal phase register ph is 0..2.
- IDLE:
  - start=1 → INIT.
  - On that edge: nonce<=NONCE_START, latch target_hi, clear found/found_nonce.
  - start while busy is ignored.
- INIT (1 cycle):
  - Block=0, nonce_sig=0; load_chunk=1, chunk_sel=0.
  - Next: RND with ph=0, round=0.
- RND:
  - round_valid=1, round increments each cycle.
  - Block holds its previous value throughout.
  - At round=ROUNDS-1: next state ADD, Block<=ph+1, round<=0.
- ADD (1 cycle): Block=ph+1, round_valid=0. The accumulators add the core output on this edge.
  - ph<2: ph<=ph+1, load_chunk=1, chunk_sel=ph+1 → RND.
  - ph=2: → CHECK.
- CHECK (1 cycle): compare digest_hi against the latched target.
  - digest_hi <= target (unsigned): found<=1, found_nonce<=nonce, done pulse → IDLE.
  - Else if nonce==NONCE_LAST: done pulse with found=0 → IDLE. No wrap-around.
  - Else: nonce<=nonce+1, nonce_sig<=1, ph<=1, load_chunk=1, chunk_sel=1 → RND. Block stays 3 and chunk1 is skipped (midstate reuse).
- Leaving for IDLE (from CHECK or via abort) returns Block to 0 and nonce_sig to 0, so the accumulators reinitialise.
- Latency, start edge to first CHECK: 3·ROUNDS+5 cycles (197 at ROUNDS=64). Each later nonce: 2·ROUNDS+3 cycles (131).
- Block sequence:
  - First nonce: 0 (INIT and chunk1 rounds), 1, 2, 3.
  - Later nonces: 3 (chunk2 rounds), 2, 3.
  - Block never changes during RND except at the RND→ADD edge.
- Abort:
  - Any non-IDLE state → IDLE on the next edge; done is not pulsed; found keeps its cleared value.
  - Abort has priority over every other transition, including a simultaneous CHECK hit.
  - abort in IDLE is a no-op.
- A CHECK hit on NONCE_LAST reports found=1, not exhausted.

Test Plan:
- ROUNDS=4, start, digest_hi=0, target_hi=0 → done at cycle 17 after start; found=1, found_nonce=0; Block trace 0,0,0,0,0,0,1,…,2,…,3.
- ROUNDS=4, target_hi=0, digest_hi=1 until nonce=3, then 0 → found_nonce=3. Later nonces each take 11 cycles with nonce_sig=1 and chunk_sel sequence 1,2. Total cycles from start to done: 17+3·11=50.
- NONCE_START=32'hFFFFFFFE, NONCE_LAST=32'hFFFFFFFF, digest never ≤ target → two CHECKs, then done=1 with found=0; nonce stays 32'hFFFFFFFF (no wrap to 0).
- Abort asserted in the RND of chunk2 → next cycle busy=0, Block=0, nonce_sig=0, done never pulses. A fresh start then repeats the first-nonce timing exactly.
- rst_n pulled low mid-HASH2 → all outputs take reset values asynchronously, before the next clk edge.
- start held high throughout a run → no restart while busy. Re-entry occurs on the cycle after done, and found is cleared then.

Source files
------------

// File: rtl/nonce_sequencer.sv
// nonce_sequencer
// Initiator side of the hash-state accumulator protocol. Walks the three
// compression passes of a double SHA-256 (header chunk1, header chunk2 with
// nonce, padded first digest), signals the accumulators through Block and
// nonce_sig, then compares the final digest top word with the target. On a
// miss it steps the nonce and reruns only chunk2 and the second hash,
// reusing the chunk1 midstate held in the accumulators.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          search control (start sampled in IDLE only)
//   target_hi             unsigned digest threshold, latched at start
//   digest_hi             H0 accumulator output (final digest top word)
//   Block, nonce_sig      phase code / midstate-reuse flag to accumulators
//   load_chunk, chunk_sel core load strobe and chunk selector
//   round, round_valid    round index and execute strobe for the core
//   nonce                 nonce under test
//   busy, done            activity level and end-of-search pulse
//   found, found_nonce    search result, held until the next start
module nonce_sequencer #(
   parameter int          ROUNDS      = 64,
   parameter logic [31:0] NONCE_START = 32'h00000000,
   parameter logic [31:0] NONCE_LAST  = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] target_hi,
   input  logic [31:0] digest_hi,
   output logic [1:0]  Block,
   output logic        nonce_sig,
   output logic        load_chunk,
   output logic [1:0]  chunk_sel,
   output logic [5:0]  round,
   output logic        round_valid,
   output logic [31:0] nonce,
   output logic        busy,
   output logic        done,
   output logic        found,
   output logic [31:0] found_nonce
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RND, S_ADD, S_CHECK} state_t;

   localparam logic [5:0] RLAST = 6'(ROUNDS - 1);

   state_t      state_q;
   logic [1:0]  ph_q;
   logic [1:0]  block_q;
   logic [1:0]  chunk_q;
   logic        sig_q;
   logic        load_q;
   logic        rv_q;
   logic        busy_q;
   logic        done_q;
   logic        found_q;
   logic [5:0]  round_q;
   logic [31:0] nonce_q;
   logic [31:0] tgt_q;
   logic [31:0] fnonce_q;

   logic        hit_d;
   logic        last_d;

   assign hit_d  = (digest_hi <= tgt_q);
   assign last_d = (nonce_q == NONCE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ph_q     <= 2'd0;
         block_q  <= 2'd0;
         chunk_q  <= 2'd0;
         sig_q    <= 1'b0;
         load_q   <= 1'b0;
         rv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         found_q  <= 1'b0;
         round_q  <= 6'd0;
         nonce_q  <= NONCE_START;
         tgt_q    <= 32'd0;
         fnonce_q <= 32'd0;
      end else begin
         load_q <= 1'b0;
         done_q <= 1'b0;
         if (abort && state_q != S_IDLE) begin
            // Abort beats every other transition, including a CHECK hit.
            state_q <= S_IDLE;
            block_q <= 2'd0;
            sig_q   <= 1'b0;
            chunk_q <= 2'd0;
            rv_q    <= 1'b0;
            round_q <= 6'd0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     state_q  <= S_INIT;
                     nonce_q  <= NONCE_START;
                     tgt_q    <= target_hi;
                     found_q  <= 1'b0;
                     fnonce_q <= 32'd0;
                     busy_q   <= 1'b1;
                     load_q   <= 1'b1;
                     chunk_q  <= 2'd0;
                     block_q  <= 2'd0;
                     sig_q    <= 1'b0;
                  end
               end
               S_INIT: begin
                  state_q <= S_RND;
                  ph_q    <= 2'd0;
                  round_q <= 6'd0;
                  rv_q    <= 1'b1;
               end
               S_RND: begin
                  // Block only moves on the RND->ADD edge so the accumulators
                  // see a stable phase code for the whole chunk.
                  if (round_q == RLAST) begin
                     state_q <= S_ADD;
                     block_q <= ph_q + 2'd1;
                     round_q <= 6'd0;
                     rv_q    <= 1'b0;
                  end else begin
                     round_q <= round_q + 6'd1;
                  end
               end
               S_ADD: begin
                  if (ph_q != 2'd2) begin
                     state_q <= S_RND;
                     ph_q    <= ph_q + 2'd1;
                     load_q  <= 1'b1;
                     chunk_q <= ph_q + 2'd1;
                     rv_q    <= 1'b1;
                  end else begin
                     state_q <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (hit_d || last_d) begin
                     // A hit on the last nonce still reports found.
                     state_q  <= S_IDLE;
                     done_q   <= 1'b1;
                     found_q  <= hit_d;
                     fnonce_q <= hit_d ? nonce_q : 32'd0;
                     block_q  <= 2'd0;
                     sig_q    <= 1'b0;
                     chunk_q  <= 2'd0;
                     busy_q   <= 1'b0;
                  end else begin
                     // Next nonce: skip chunk1, the midstate is already in
                     // the accumulators; Block stays at 3 until chunk2 ends.
                     state_q <= S_RND;
                     nonce_q <= nonce_q + 32'd1;
                     sig_q   <= 1'b1;
                     ph_q    <= 2'd1;
                     load_q  <= 1'b1;
                     chunk_q <= 2'd1;
                     rv_q    <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign Block       = block_q;
   assign nonce_sig   = sig_q;
   assign load_chunk  = load_q;
   assign chunk_sel   = chunk_q;
   assign round       = round_q;
   assign round_valid = rv_q;
   assign nonce       = nonce_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign found       = found_q;
   assign found_nonce = fnonce_q;

endmodule

// File: tb/tb_nonce_sequencer.sv
module tb_nonce_sequencer;

   localparam int          R  = 4;
   localparam logic [31:0] NS = 32'hFFFFFFF8;
   localparam logic [31:0] NL = 32'hFFFFFFFF;
   localparam int          N  = 8;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [31:0] target_hi;
   logic [31:0] digest_hi;
   logic [1:0]  Block;
   logic        nonce_sig;
   logic        load_chunk;
   logic [1:0]  chunk_sel;
   logic [5:0]  round;
   logic        round_valid;
   logic [31:0] nonce;
   logic        busy;
   logic        done;
   logic        found;
   logic [31:0] found_nonce;

   nonce_sequencer #(.ROUNDS(R), .NONCE_START(NS), .NONCE_LAST(NL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .target_hi(target_hi), .digest_hi(digest_hi), .Block(Block),
      .nonce_sig(nonce_sig), .load_chunk(load_chunk), .chunk_sel(chunk_sel),
      .round(round), .round_valid(round_valid), .nonce(nonce), .busy(busy),
      .done(done), .found(found), .found_nonce(found_nonce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator stand-in: final digest top word per nonce offset.
   logic [31:0] dig [N];
   logic [31:0] didx;
   always_comb begin
      didx      = nonce - NS;
      digest_hi = (didx < 32'(N)) ? dig[didx[2:0]] : 32'hFFFFFFFF;
   end

   typedef struct {
      bit          fnd;
      logic [31:0] fnonce;
      logic [31:0] last_nonce;
      int          cycles;
   } exp_t;

   exp_t exp_q[$];
   int   ld_q[$];
   int   blk_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic flush();
      exp_q.delete();
      ld_q.delete();
      blk_q.delete();
   endtask

   // Reference model: scan nonces in order, first digest <= target wins.
   task automatic model_push(input logic [31:0] tgt, input int copies);
      exp_t e;
      int   k;
      int   nchk;
      k = N;
      for (int i = 0; i < N; i++) begin
         if (dig[i] <= tgt) begin
            k = i;
            break;
         end
      end
      nchk         = (k < N) ? k + 1 : N;
      e.fnd        = (k < N);
      e.fnonce     = e.fnd ? NS + 32'(k) : 32'd0;
      e.last_nonce = NS + 32'(nchk - 1);
      e.cycles     = 3 * R + 5 + (nchk - 1) * (2 * R + 3);
      for (int c = 0; c < copies; c++) begin
         exp_q.push_back(e);
         ld_q.push_back(0); ld_q.push_back(1); ld_q.push_back(2);
         blk_q.push_back(1); blk_q.push_back(2); blk_q.push_back(3);
         for (int j = 1; j < nchk; j++) begin
            ld_q.push_back(1 + 4); ld_q.push_back(2 + 4);
            blk_q.push_back(2); blk_q.push_back(3);
         end
      end
   endtask

   // Monitor
   int         cyc = 0;
   int         start_cyc = 0;
   int         rcnt = 0;
   logic [1:0] prev_blk = 2'd0;
   logic       prev_busy = 1'b0;
   bit         hold_chk = 0;
   bit         hold_found = 0;

   always @(negedge clk) begin : monitor
      int   v;
      exp_t e;
      cyc++;
      if (!rst_n) begin
         rcnt     = 0;
         hold_chk = 0;
      end else begin
         if (hold_chk && !busy) check("found_hold", found, hold_found);
         hold_chk = 0;
         if (busy && !prev_busy) begin
            start_cyc = cyc;
            check("found_clear_at_start", found, 0);
         end
         if (round_valid) begin
            check("round_index", round, rcnt);
            rcnt++;
         end else begin
            rcnt = 0;
         end
         if (load_chunk && ld_q.size() > 0) begin
            v = ld_q.pop_front();
            check("chunk_sel", chunk_sel, v % 4);
            check("nonce_sig_at_load", nonce_sig, v / 4);
         end
         if (busy && Block != prev_blk && blk_q.size() > 0) begin
            v = blk_q.pop_front();
            check("block_step", Block, v);
            check("block_step_outside_rnd", round_valid, 0);
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               e = exp_q.pop_front();
               check("found", found, e.fnd);
               check("found_nonce", found_nonce, e.fnonce);
               check("final_nonce", nonce, e.last_nonce);
               check("latency", cyc - start_cyc, e.cycles);
               check("busy_at_done", busy, 0);
               hold_chk   = 1;
               hold_found = e.fnd;
            end
         end
      end
      prev_busy = busy;
      prev_blk  = Block;
   end

   task automatic wait_idle();
      int n = 0;
      while (exp_q.size() > 0 && n < 600) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > 0) begin
         check("run_timeout", exp_q.size(), 0);
         flush();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic run(input logic [31:0] tgt);
      model_push(tgt, 1);
      target_hi = tgt;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      target_hi = $urandom;  // must have been latched at start
      wait_idle();
   endtask

   task automatic wait_load(input logic [1:0] sel, output bit ok);
      int n = 0;
      ok = 0;
      while (n < 100 && !ok) begin
         @(posedge clk); #1;
         n++;
         if (load_chunk && chunk_sel == sel) ok = 1;
      end
      if (!ok) check("load_wait_timeout", 1, 0);
   endtask

   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < N; i++) dig[i] = v;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_block"}, Block, 0);
      check({tag, "_nonce_sig"}, nonce_sig, 0);
      check({tag, "_round_valid"}, round_valid, 0);
      check({tag, "_load_chunk"}, load_chunk, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      bit          ok;
      logic [31:0] t;
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; target_hi = 32'd0;
      fill(32'hFFFFFFFF);
      #1 rst_n = 1'b0;
      #2;
      check_idle_outputs("reset");
      check("reset_nonce", nonce, NS);
      check("reset_found", found, 0);
      check("reset_found_nonce", found_nonce, 0);
      check("reset_round", round, 0);
      check("reset_chunk_sel", chunk_sel, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // First nonce hit: 17 cycles.
      fill(32'd0);
      run(32'd0);

      // Abort in IDLE is a no-op; result stays visible.
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("idle_abort_busy", busy, 0);
      check("idle_abort_found", found, 1);

      // Hit on the fourth nonce: 17 + 3*11 = 50 cycles.
      fill(32'd1);
      dig[3] = 32'd0;
      run(32'd0);

      // Exhaustion: no wrap past NONCE_LAST.
      fill(32'd6);
      run(32'd5);

      // Hit exactly on NONCE_LAST with digest equal to target.
      fill(32'd6);
      dig[N-1] = 32'd5;
      run(32'd5);

      // Abort during chunk2 rounds, then a clean restart.
      fill(32'd0);
      target_hi = 32'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_load(2'd1, ok);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_idle_outputs("abort_rnd");
      repeat (20) @(posedge clk);
      #1;
      run(32'd0);

      // Abort coincident with a CHECK hit wins.
      fill(32'd0);
      target_hi = 32'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3 * R + 4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_idle_outputs("abort_check");
      check("abort_check_found", found, 0);
      repeat (10) @(posedge clk);
      #1;

      // Asynchronous reset during the second hash.
      fill(32'd9);
      target_hi = 32'd0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_load(2'd2, ok);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      check("async_reset_nonce", nonce, NS);
      check("async_reset_round", round, 0);
      check("async_reset_chunk_sel", chunk_sel, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      flush();
      repeat (2) @(posedge clk);
      #1;

      // start held high: ignored while busy, re-entry right after done.
      fill(32'd7);
      dig[1] = 32'd3;
      model_push(32'd3, 2);
      target_hi = 32'd3;
      start = 1'b1;
      while (exp_q.size() > 1 && cyc < 20000) @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // Randomized searches.
      for (int r = 0; r < 8; r++) begin
         t = $urandom_range(0, 32'hFFFF0000);
         for (int i = 0; i < N; i++)
            dig[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(0, t)
                                                 : t + 32'd1 + $urandom_range(0, 1000);
         run(t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
